score_display_mux: RTL and testbench

- Parametrised successor to the game's 4-bit score counter and single-digit 7-segment path.
- Holds an N-digit BCD score and counts rising edges of REACHED_TARGET.
- Raises WIN when the score reaches a decimal threshold.
- Time-multiplexes all digits onto the shared 7-segment bus (SEG_SELECT/HEX_OUT).
- Sits between SnakeControl (target events) and the board display; WIN feeds the master state machine.

---
 rtl/score_display_pkg.sv | 22 ++
 rtl/score_display_mux_bcd_seg7_decoder.sv | 27 ++
 rtl/score_display_mux.sv | 145 ++++++++++++++
 tb/tb_score_display_mux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared types and seven-segment constants for the score display
package score_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal point position within the 8-bit HEX_OUT bus
    localparam int DP_BIT = 7;

endpackage

// File: rtl/score_display_mux_bcd_seg7_decoder.sv
// rtl/score_display_mux_bcd_seg7_decoder.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_seg7_decoder
    import score_display_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    // Map one BCD digit to its segment pattern; anything else blanks
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - BCD score counter with win flag and strobed 7-segment output (option: SCORE_LEADING_ZERO_BLANK_EN)
module score_display_mux
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STROBE_DIV   = 50000,
    parameter int TARGET_SCORE = 10,
    parameter int SATURATE     = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    REACHED_TARGET,
    input  logic                    CLEAR,
    output logic [4*NUM_DIGITS-1:0] SCORE_BCD,
    output logic                    WIN,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT,
    output logic [7:0]              HEX_OUT
);

    localparam int CNT_W = $clog2(STROBE_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] TARGET = 32'(TARGET_SCORE);

    logic                    prev_q;
    logic [4*NUM_DIGITS-1:0] score_q, score_d;
    logic                    win_q, win_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic [7:0]              hex_q, hex_d;

    logic                    inc;
    logic                    tick;
    logic                    all_nines;
    logic                    carry;
    logic [31:0]             score_val;
    bcd_digit_t              digit_sel;
    logic [6:0]              seg_raw;
    logic                    blank_sel;

    assign inc  = REACHED_TARGET & ~prev_q;
    assign tick = (cnt_q == CNT_W'(STROBE_DIV - 1));

    // Next score: clear wins over increment; ripple BCD carry from the units digit up
    always_comb begin
        score_d   = score_q;
        all_nines = 1'b1;
        carry     = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (score_q[4*k +: 4] != 4'd9) all_nines = 1'b0;
        end
        if (CLEAR) begin
            score_d = '0;
        end else if (inc) begin
            if (all_nines) begin
                score_d = (SATURATE != 0) ? score_q : '0;
            end else begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (carry) begin
                        if (score_q[4*k +: 4] == 4'd9) begin
                            score_d[4*k +: 4] = 4'd0;
                        end else begin
                            score_d[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Binary value of the registered score, compared against the win threshold
    always_comb begin
        score_val = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            score_val = score_val * 32'd10 + 32'(score_q[4*k +: 4]);
        end
        win_d = (score_val >= TARGET);
    end

    assign digit_sel = score_q[4*int'(idx_q) +: 4];

    bcd_seg7_decoder u_dec (
        .digit (digit_sel),
        .seg   (seg_raw)
    );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Blank the selected digit when it and every higher digit are zero (never digit 0)
    always_comb begin
        zero_above = 1'b1;
        blank_sel  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (score_q[4*k +: 4] == 4'd0);
            if ((idx_q == IDX_W'(k)) && zero_above) blank_sel = 1'b1;
        end
    end
`else
    assign blank_sel = 1'b0;
`endif

    // Strobe counter and display registers: latch the current digit at each tick, then advance
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        seg_sel_d = seg_sel_q;
        hex_d     = hex_q;
        if (tick) begin
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            seg_sel_d = ~(NUM_DIGITS'(1) << idx_q);
            hex_d     = {1'b1, seg_raw};
            hex_d[DP_BIT] = ~((idx_q == '0) & win_q);
            if (blank_sel) hex_d = 8'hFF;
        end
    end

    // State registers with asynchronous reset to a dark display and zero score
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q    <= 1'b0;
            score_q   <= '0;
            win_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_sel_q <= '1;
            hex_q     <= 8'hFF;
        end else begin
            prev_q    <= REACHED_TARGET;
            score_q   <= score_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_sel_q <= seg_sel_d;
            hex_q     <= hex_d;
        end
    end

    assign SCORE_BCD  = score_q;
    assign WIN        = win_q;
    assign SEG_SELECT = seg_sel_q;
    assign HEX_OUT    = hex_q;

endmodule

// File: tb/tb_score_display_mux.sv
// tb/tb_score_display_mux.sv - randomized self-checking bench for score_display_mux
module tb_score_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rt  = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] score0, score1;
    logic        win0, win1;
    logic [3:0]  seg0, seg1;
    logic [7:0]  hex0, hex1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_score [2];
    bit         m_win   [2];
    bit         m_prev;
    int         m_cyc;
    logic [3:0] m_seg;
    logic [7:0] m_hex [2];
    logic [7:0] seg_tab [10];

    always #5 clk = ~clk;

    score_display_mux #(.NUM_DIGITS(4), .STROBE_DIV(4), .TARGET_SCORE(10), .SATURATE(1)) u_sat (
        .CLK(clk), .RESET(rst), .REACHED_TARGET(rt), .CLEAR(clr),
        .SCORE_BCD(score0), .WIN(win0), .SEG_SELECT(seg0), .HEX_OUT(hex0)
    );

    score_display_mux #(.NUM_DIGITS(4), .STROBE_DIV(4), .TARGET_SCORE(10), .SATURATE(0)) u_wrap (
        .CLK(clk), .RESET(rst), .REACHED_TARGET(rt), .CLEAR(clr),
        .SCORE_BCD(score1), .WIN(win1), .SEG_SELECT(seg1), .HEX_OUT(hex1)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_hex(input int score, input bit win, input int k);
        int p;
        logic [7:0] r;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (k > 0 && score < p) return 8'hFF;
`endif
        r = seg_tab[(score / p) % 10];
        if (k == 0 && win) r[7] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_score[0] = 0; m_score[1] = 0;
        m_win[0] = 0;   m_win[1] = 0;
        m_prev = 0; m_cyc = 0;
        m_seg = 4'hF;
        m_hex[0] = 8'hFF; m_hex[1] = 8'hFF;
    endtask

    // One clock with the given inputs; model advanced in step, outputs sampled 1 unit after the edge
    task automatic step(input bit r_in, input bit c_in);
        bit inc;
        int k;
        rt  = r_in;
        clr = c_in;
        @(posedge clk);
        inc = r_in && !m_prev;
        if ((m_cyc + 1) % 4 == 0) begin
            k = ((m_cyc + 1) / 4 - 1) % 4;
            m_seg = ~(4'b0001 << k);
            for (int j = 0; j < 2; j++) m_hex[j] = exp_hex(m_score[j], m_win[j], k);
        end
        for (int j = 0; j < 2; j++) begin
            m_win[j] = (m_score[j] >= 10);
            if (c_in) m_score[j] = 0;
            else if (inc) begin
                if (m_score[j] == 9999) m_score[j] = (j == 0) ? 9999 : 0;
                else m_score[j] = m_score[j] + 1;
            end
        end
        m_prev = r_in;
        m_cyc++;
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0);
            step(0, 0);
        end
    endtask

    task automatic test_reset();
        pulses(7);
        n_checks++;
        if (score0 !== 16'h0007) begin n_errors++; $display("FAIL pre_reset_score: got %h expected %h", score0, 16'h0007); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (score0 !== 16'h0000) begin n_errors++; $display("FAIL reset_score: got %h expected %h", score0, 16'h0000); end
        n_checks++;
        if (win0 !== 1'b0) begin n_errors++; $display("FAIL reset_win: got %b expected 0", win0); end
        n_checks++;
        if (seg0 !== 4'b1111) begin n_errors++; $display("FAIL reset_seg: got %b expected 1111", seg0); end
        n_checks++;
        if (hex0 !== 8'hFF) begin n_errors++; $display("FAIL reset_hex: got %h expected FF", hex0); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_checks++;
            if (seg0 !== 4'b1111) begin n_errors++; $display("FAIL pre_tick_seg cycle %0d: got %b expected 1111", i, seg0); end
        end
        step(0, 0);
        n_checks++;
        if (seg0 !== 4'b1110) begin n_errors++; $display("FAIL first_tick_seg: got %b expected 1110", seg0); end
        n_checks++;
        if (hex0 !== 8'hC0) begin n_errors++; $display("FAIL first_tick_hex: got %h expected C0", hex0); end
    endtask

    task automatic test_edge_count();
        for (int i = 0; i < 20; i++) step(1, 0);
        step(0, 0);
        n_checks++;
        if (score0 !== 16'h0001) begin n_errors++; $display("FAIL held_level_score: got %h expected 0001", score0); end
        for (int i = 0; i < 9; i++) begin
            step(1, 0);
            n_checks++;
            if (score0 !== to_bcd(m_score[0]) || win0 !== m_win[0]) begin
                n_errors++; $display("FAIL pulse_%0d: got %h/%b expected %h/%b", i, score0, win0, to_bcd(m_score[0]), m_win[0]);
            end
            if (i == 8) begin
                n_checks++;
                if (score0 !== 16'h0010 || win0 !== 1'b0) begin n_errors++; $display("FAIL reach_ten: got %h/%b expected 0010/0", score0, win0); end
            end
            step(0, 0);
        end
        n_checks++;
        if (win0 !== 1'b1) begin n_errors++; $display("FAIL win_rise: got %b expected 1", win0); end
    endtask

    task automatic test_strobe_dp();
        pulses(2);
        for (int i = 0; i < 40; i++) begin
            step(0, 0);
            n_checks++;
            if (seg0 !== m_seg || hex0 !== m_hex[0]) begin
                n_errors++; $display("FAIL strobe cycle %0d: got %b/%h expected %b/%h", i, seg0, hex0, m_seg, m_hex[0]);
            end
            if (m_seg == 4'b1110) begin
                n_checks++;
                if (hex0 !== 8'h24) begin n_errors++; $display("FAIL digit0_dp cycle %0d: got %h expected 24", i, hex0); end
            end
        end
    endtask

    task automatic test_clear();
        pulses(3);
        n_checks++;
        if (score0 !== 16'h0015) begin n_errors++; $display("FAIL pre_clear_score: got %h expected 0015", score0); end
        step(1, 1);
        n_checks++;
        if (score0 !== 16'h0000 || score1 !== 16'h0000) begin n_errors++; $display("FAIL clear_priority: got %h/%h expected 0000", score0, score1); end
        n_checks++;
        if (win0 !== 1'b1) begin n_errors++; $display("FAIL clear_win_hold: got %b expected 1", win0); end
        step(0, 0);
        n_checks++;
        if (win0 !== 1'b0) begin n_errors++; $display("FAIL clear_win_fall: got %b expected 0", win0); end
    endtask

    task automatic test_saturate_wrap();
        pulses(9999);
        n_checks++;
        if (score0 !== 16'h9999 || score1 !== 16'h9999) begin n_errors++; $display("FAIL preload: got %h/%h expected 9999", score0, score1); end
        step(1, 0);
        n_checks++;
        if (score0 !== 16'h9999) begin n_errors++; $display("FAIL saturate: got %h expected 9999", score0); end
        n_checks++;
        if (score1 !== 16'h0000) begin n_errors++; $display("FAIL wrap: got %h expected 0000", score1); end
        step(0, 0);
        n_checks++;
        if (win1 !== 1'b0) begin n_errors++; $display("FAIL wrap_win: got %b expected 0", win1); end
        n_checks++;
        if (win0 !== 1'b1) begin n_errors++; $display("FAIL saturate_win: got %b expected 1", win0); end
        step(0, 1);
        step(0, 0);
    endtask

    task automatic test_blanking();
        pulses(5);
        for (int i = 0; i < 20; i++) begin
            step(0, 0);
            n_checks++;
            if (seg0 !== m_seg || hex0 !== m_hex[0]) begin
                n_errors++; $display("FAIL blank cycle %0d: got %b/%h expected %b/%h", i, seg0, hex0, m_seg, m_hex[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            n_checks++;
            if (score0 !== to_bcd(m_score[0]) || score1 !== to_bcd(m_score[1])) begin
                n_errors++; $display("FAIL rand_score %0d: got %h/%h expected %h/%h", i, score0, score1, to_bcd(m_score[0]), to_bcd(m_score[1]));
            end
            n_checks++;
            if (win0 !== m_win[0] || win1 !== m_win[1]) begin
                n_errors++; $display("FAIL rand_win %0d: got %b/%b expected %b/%b", i, win0, win1, m_win[0], m_win[1]);
            end
            n_checks++;
            if (seg0 !== m_seg || seg1 !== m_seg || hex0 !== m_hex[0] || hex1 !== m_hex[1]) begin
                n_errors++; $display("FAIL rand_disp %0d: got %b/%b %h/%h expected %b %h/%h", i, seg0, seg1, hex0, hex1, m_seg, m_hex[0], m_hex[1]);
            end
        end
    endtask

    initial begin
        seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
        seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
        seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_edge_count();
        test_strobe_dp();
        test_clear();
        test_saturate_wrap();
        test_blanking();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
